maxpool_layer: RTL and testbench

MAXPOOL_LAYER -- requirements
Module: maxpool_layer

---
 rtl/maxpool_layer.sv | 141 ++++++++++++++
 tb/tb_maxpool_layer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/maxpool_layer.sv
// 2x2 stride-2 max pooling over a raster, channel-minor pixel stream.
// One pooled line is kept in a buffer indexed by (col/2, channel).
module maxpool_layer #(
  parameter int channels      = 384,
  parameter int img_width     = 11,
  parameter int datatype_size = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  output logic                        o_busy,
  input  logic                        i_valid,
  input  logic [datatype_size-1:0]    i_data,
  output logic                        o_ready,
  output logic                        o_valid,
  output logic [datatype_size-1:0]    o_data,
  output logic [$clog2(channels)-1:0] o_channel,
  input  logic                        i_ready,
  output logic                        o_done
);

  localparam int POOLED = img_width / 2;
  localparam int NBUF   = POOLED * channels;
  localparam int IW     = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int CW     = $clog2(channels);
  localparam int PW     = $clog2(img_width + 1);
  localparam logic [CW-1:0] C_LAST = CW'(channels - 1);
  localparam logic [PW-1:0] P_LAST = PW'(img_width - 1);
  localparam logic [PW-1:0] P_EDGE = PW'(2 * POOLED);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_c;
  logic [PW-1:0]            r_col;
  logic [PW-1:0]            r_row;
  logic                     r_in_done;
  logic                     r_busy;
  logic                     r_valid;
  logic                     r_done;
  logic [datatype_size-1:0] r_data;
  logic [CW-1:0]            r_chan;
  logic [datatype_size-1:0] r_buf [NBUF];

  logic                     w_xfer;
  logic                     w_c_wrap;
  logic                     w_col_wrap;
  logic                     w_last;
  logic                     w_in_pool;
  logic                     w_emit;
  logic [IW-1:0]            w_idx;
  logic [datatype_size-1:0] w_entry;
  logic [datatype_size-1:0] w_max;

  assign o_ready    = (r_state == S_RUN) && (!r_valid || i_ready);
  // Once the final value is in, further beats are not part of this frame.
  assign w_xfer     = i_valid && o_ready && !r_in_done;
  assign w_c_wrap   = (r_c == C_LAST);
  assign w_col_wrap = (r_col == P_LAST);
  assign w_last     = w_c_wrap && w_col_wrap && (r_row == P_LAST);
  assign w_in_pool  = (r_col < P_EDGE) && (r_row < P_EDGE);
  assign w_emit     = w_xfer && w_in_pool && r_row[0] && r_col[0];
  assign w_idx      = IW'((int'(r_col) / 2) * channels + int'(r_c));
  assign w_entry    = r_buf[w_idx];
  assign w_max      = (w_entry > i_data) ? w_entry : i_data;

  assign o_busy     = r_busy;
  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_channel  = r_chan;
  assign o_done     = r_done;

  always_ff @(posedge clk) begin
    if (w_xfer && w_in_pool && !(r_row[0] && r_col[0])) begin
      r_buf[w_idx] <= (r_row[0] || r_col[0]) ? w_max : i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_c       <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_in_done <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= '0;
      r_chan    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_c       <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_in_done <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (w_last) r_in_done <= 1'b1;
            if (w_c_wrap) begin
              r_c <= '0;
              if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_last ? '0 : r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end else begin
              r_c <= r_c + 1'b1;
            end
          end
          if (r_in_done && !r_valid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_emit) begin
        r_valid <= 1'b1;
        r_data  <= w_max;
        r_chan  <= r_c;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_layer.sv
// Bench for maxpool_layer: an even-width (4) and an odd-width (5) instance
// share the input stream; a per-window max model predicts every output.
module tb_maxpool_layer;
  localparam int CH  = 2;
  localparam int W_A = 4;
  localparam int W_B = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start_a, start_b, i_valid, i_ready;
  logic [3:0] i_data;

  logic       a_busy, a_ready, a_valid, a_done;
  logic [3:0] a_data;
  logic [0:0] a_chan;
  logic       b_busy, b_ready, b_valid, b_done;
  logic [3:0] b_data;
  logic [0:0] b_chan;

  maxpool_layer #(.channels(CH), .img_width(W_A), .datatype_size(4)) u_dut_a (
    .clk(clk), .rst(rst), .i_start(start_a), .o_busy(a_busy),
    .i_valid(i_valid), .i_data(i_data), .o_ready(a_ready),
    .o_valid(a_valid), .o_data(a_data), .o_channel(a_chan),
    .i_ready(i_ready), .o_done(a_done));

  maxpool_layer #(.channels(CH), .img_width(W_B), .datatype_size(4)) u_dut_b (
    .clk(clk), .rst(rst), .i_start(start_b), .o_busy(b_busy),
    .i_valid(i_valid), .i_data(i_data), .o_ready(b_ready),
    .o_valid(b_valid), .o_data(b_data), .o_channel(b_chan),
    .i_ready(i_ready), .o_done(b_done));

  logic       sel;
  logic       busy, rdy, vld, done;
  logic [3:0] dat;
  logic [0:0] chn;

  always_comb begin
    busy = a_busy; rdy = a_ready; vld = a_valid; done = a_done; dat = a_data; chn = a_chan;
    if (sel) begin
      busy = b_busy; rdy = b_ready; vld = b_valid; done = b_done; dat = b_data; chn = b_chan;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int stim[$];
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs: for each pooled pixel and channel, the max of its 2x2 window.
  function automatic void build_exp(input int w);
    int m, v;
    exp_q.delete();
    for (int pr = 0; pr < w / 2; pr++)
      for (int pc = 0; pc < w / 2; pc++)
        for (int c = 0; c < CH; c++) begin
          m = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              v = stim[((2 * pr + dr) * w + 2 * pc + dc) * CH + c];
              if (v > m) m = v;
            end
          exp_q.push_back(c * 256 + m);
        end
  endfunction

  function automatic void make_ramp();
    stim.delete();
    for (int r = 0; r < W_A; r++)
      for (int c = 0; c < W_A; c++) begin
        stim.push_back(4 * r + c);
        stim.push_back(15 - (4 * r + c));
      end
  endfunction

  function automatic void make_random(input int w);
    stim.delete();
    for (int k = 0; k < w * w * CH; k++) stim.push_back(int'($urandom_range(15)));
  endfunction

  task automatic reset_and_check(input logic need_valid);
    if (need_valid) check("valid_before_rst", 32'(vld), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ready", 32'(rdy),  32'd0);
    check("rst_valid", 32'(vld),  32'd0);
    check("rst_data",  32'(dat),  32'd0);
    check("rst_chan",  32'(chn),  32'd0);
    check("rst_done",  32'(done), 32'd0);
    i_valid = 1'b0; start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // rmode: 0 = valid/ready high, 1 = random handshakes, 2 = ready held low.
  task automatic run_frame(input int w, input int rmode, input bit stall3, input bit mid_start,
                           input int abort_n, input bit abort_on_valid);
    int idx, cyc, stall_seen, done_cnt, e;
    bit finished, st;
    idx = 0; cyc = 0; stall_seen = 0; done_cnt = 0; finished = 0;
    sel = (w == W_B);
    while (!finished && cyc < 3000) begin
      @(posedge clk); #1;
      if (abort_n >= 0 && idx >= abort_n && (!abort_on_valid || vld)) begin
        reset_and_check(abort_on_valid);
        return;
      end
      st = (cyc == 0) || (mid_start && cyc == 12);
      start_a = st && !sel;
      start_b = st && sel;
      i_valid = (idx < stim.size()) && (rmode != 1 || $urandom_range(3) != 0);
      i_data  = (idx < stim.size()) ? 4'(stim[idx]) : 4'd0;
      if (rmode == 2)      i_ready = 1'b0;
      else if (stall3)     i_ready = (stall_seen >= 3);
      else if (rmode == 1) i_ready = ($urandom_range(2) != 0);
      else                 i_ready = 1'b1;
      @(negedge clk);
      if (stall3 && vld && !i_ready) begin
        check("stall_data",  32'(dat), 32'(exp_q[0] % 256));
        check("stall_ready", 32'(rdy), 32'd0);
        stall_seen++;
      end
      if (vld && i_ready) begin
        if (exp_q.size() == 0) check("extra_output", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("out_chan", 32'(chn), 32'(e / 256));
          check("out_data", 32'(dat), 32'(e % 256));
        end
      end
      if (i_valid && rdy) idx++;
      if (done) begin
        done_cnt++;
        check("busy_in_done", 32'(busy), 32'd1);
        check("outputs_left", 32'(exp_q.size()), 32'd0);
        check("inputs_taken", 32'(idx), 32'(stim.size()));
      end else if (done_cnt > 0) begin
        check("busy_after_done", 32'(busy), 32'd0);
        finished = 1;
      end
      cyc++;
    end
    i_valid = 1'b0; start_a = 1'b0; start_b = 1'b0;
    check("frame_finished", 32'(finished), 32'd1);
    check("done_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    sel = 1'b0; start_a = 1'b0; start_b = 1'b0;
    i_valid = 1'b0; i_ready = 1'b1; i_data = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("init_busy",  32'(busy), 32'd0);
    check("init_ready", 32'(rdy),  32'd0);
    check("init_valid", 32'(vld),  32'd0);
    check("init_data",  32'(dat),  32'd0);
    check("init_chan",  32'(chn),  32'd0);
    check("init_done",  32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    make_ramp(); build_exp(W_A); run_frame(W_A, 0, 0, 0, -1, 0);
    make_ramp(); build_exp(W_A); run_frame(W_A, 0, 1, 0, -1, 0);

    stim.delete();
    for (int r = 0; r < W_B; r++)
      for (int c = 0; c < W_B; c++)
        for (int ch = 0; ch < CH; ch++) stim.push_back((r == 4 || c == 4) ? 9 : 1);
    build_exp(W_B); run_frame(W_B, 0, 0, 0, -1, 0);

    make_ramp(); build_exp(W_A); run_frame(W_A, 2, 0, 0, 0, 1);
    make_ramp(); build_exp(W_A); run_frame(W_A, 0, 0, 0, 10, 0);
    make_ramp(); build_exp(W_A); run_frame(W_A, 0, 0, 0, -1, 0);
    make_ramp(); build_exp(W_A); run_frame(W_A, 0, 0, 1, -1, 0);

    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin make_random(W_A); build_exp(W_A); run_frame(W_A, 1, 0, 0, -1, 0); end
      else            begin make_random(W_B); build_exp(W_B); run_frame(W_B, 1, 0, 0, -1, 0); end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
